// File: rtl/vram_pkg.sv
// Shared types, widths and defaults for the VRAM arbiter and its pending-request latch.
package vram_pkg;

  localparam int MEM_LAT_DEF = 2;
  localparam int VID_AW      = 14;
  localparam int MEM_AW      = 15;
  localparam int DW          = 16;
  localparam int LAT_W       = 3;

  typedef enum logic [2:0] {
    IDLE,
    VID,
    CPU_RD,
    CPU_WR,
    DONE
  } arb_state_t;

  // A CPU write with no byte lanes selected means a full-word write.
  function automatic logic [1:0] write_be(input logic [1:0] wtbt);
    return (wtbt == 2'b00) ? 2'b11 : wtbt;
  endfunction

endpackage

// File: rtl/vram_req_latch.sv
// One-entry holding register for a video fetch that arrives while the arbiter is busy.
module vram_req_latch
  import vram_pkg::*;
(
  input  logic              clk_bus,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [VID_AW-1:0] req_addr,
  input  logic              req_bank,
  output logic              pend_valid,
  output logic [VID_AW-1:0] pend_addr,
  output logic              pend_bank,
  output logic              overrun
);

  always_ff @(posedge clk_bus) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the stored address and bank are cleared along with the valid
      // bit so a freshly reset entry never exposes stale request data.
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_bank  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // A pop frees the slot in the same cycle, so a simultaneous push reloads it.
      if (push && (!pend_valid || pop)) begin
        pend_valid <= 1'b1;
        pend_addr  <= req_addr;
        pend_bank  <= req_bank;
      end else if (pop) begin
        pend_valid <= 1'b0;
      end
      if (push && pend_valid && !pop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates a single-port VRAM between video word fetches (priority) and a
// strobe/ack CPU port; memory strobes and data paths are registered.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk_bus,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [VID_AW-1:0] vid_addr,
  input  logic              vid_bank,
  output logic [DW-1:0]     vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_stb,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_wtbt,
  input  logic [MEM_AW-1:0] cpu_addr,
  input  logic [DW-1:0]     cpu_din,
  output logic [DW-1:0]     cpu_dout,
  output logic              cpu_ack,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_din,
  output logic [1:0]        mem_be,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic [DW-1:0]     mem_dout
);

  arb_state_t        state, state_d;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
  logic              armed, armed_d;
  logic              vid_valid_d, mem_we_d, mem_rd_d;
  logic [DW-1:0]     vid_data_d, cpu_dout_d, mem_din_d;
  logic [MEM_AW-1:0] mem_addr_d;
  logic [1:0]        mem_be_d;
  logic              lat_done;
  logic              pend_valid, pend_bank, pend_push, pend_pop;
  logic [VID_AW-1:0] pend_addr;

  assign lat_done  = (lat_cnt == LAT_W'(MEM_LAT));
  // The pending entry is consumed on any IDLE cycle; a fresh request is only
  // served directly when nothing older is waiting.
  assign pend_pop  = (state == IDLE) && pend_valid;
  assign pend_push = vid_req && ((state != IDLE) || pend_valid);
  assign cpu_ack   = (state == DONE);

  vram_req_latch u_req_latch (
    .clk_bus    (clk_bus),
    .reset      (reset),
    .push       (pend_push),
    .pop        (pend_pop),
    .req_addr   (vid_addr),
    .req_bank   (vid_bank),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_bank  (pend_bank),
    .overrun    (vid_overrun)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    state_d     = state;
    lat_cnt_d   = lat_cnt;
    vid_valid_d = 1'b0;
    vid_data_d  = vid_data;
    cpu_dout_d  = cpu_dout;
    mem_addr_d  = mem_addr;
    mem_din_d   = mem_din;
    mem_be_d    = mem_be;
    mem_we_d    = 1'b0;
    mem_rd_d    = 1'b0;
    // The CPU port disarms on completion and re-arms only once the strobe is seen low.
    if (state == DONE) begin
      armed_d = 1'b0;
    end else if (!cpu_stb) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed;
    end

    unique case (state)
      IDLE: begin
        lat_cnt_d = '0;
        if (vid_req || pend_valid) begin
          state_d    = VID;
          mem_rd_d   = 1'b1;
          mem_be_d   = 2'b11;
          mem_addr_d = pend_valid ? {pend_bank, pend_addr} : {vid_bank, vid_addr};
        end else if (cpu_stb && armed) begin
          mem_addr_d = cpu_addr;
          if (cpu_we) begin
            state_d   = CPU_WR;
            mem_we_d  = 1'b1;
            mem_din_d = cpu_din;
            mem_be_d  = write_be(cpu_wtbt);
          end else begin
            state_d  = CPU_RD;
            mem_rd_d = 1'b1;
            mem_be_d = 2'b11;
          end
        end
      end
      VID: begin
        lat_cnt_d = lat_cnt + LAT_W'(1);
        if (lat_done) begin
          vid_data_d  = mem_dout;
          vid_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      CPU_RD: begin
        lat_cnt_d = lat_cnt + LAT_W'(1);
        if (lat_done) begin
          cpu_dout_d = mem_dout;
          state_d    = DONE;
        end
      end
      CPU_WR:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      armed     <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      cpu_dout  <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_be    <= 2'b11;
      mem_we    <= 1'b0;
      mem_rd    <= 1'b0;
    end else begin
      state     <= state_d;
      lat_cnt   <= lat_cnt_d;
      armed     <= armed_d;
      vid_valid <= vid_valid_d;
      vid_data  <= vid_data_d;
      cpu_dout  <= cpu_dout_d;
      mem_addr  <= mem_addr_d;
      mem_din   <= mem_din_d;
      mem_be    <= mem_be_d;
      mem_we    <= mem_we_d;
      mem_rd    <= mem_rd_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a latency-2 VRAM model plus hand-computed expectations.
module tb_vram_arbiter;

  localparam int LAT = 2;

  logic        clk_bus = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic        vid_bank;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic        vid_overrun;
  logic        cpu_stb;
  logic        cpu_we;
  logic [1:0]  cpu_wtbt;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_ack;
  logic [14:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        mem_we;
  logic        mem_rd;
  logic [15:0] mem_dout;

  vram_arbiter #(.MEM_LAT(LAT)) dut (
    .clk_bus     (clk_bus),
    .reset       (reset),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_bank    (vid_bank),
    .vid_data    (vid_data),
    .vid_valid   (vid_valid),
    .vid_overrun (vid_overrun),
    .cpu_stb     (cpu_stb),
    .cpu_we      (cpu_we),
    .cpu_wtbt    (cpu_wtbt),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .cpu_ack     (cpu_ack),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_be      (mem_be),
    .mem_we      (mem_we),
    .mem_rd      (mem_rd),
    .mem_dout    (mem_dout)
  );

  always #5 clk_bus = ~clk_bus;

  int cyc = 0;
  always @(posedge clk_bus) cyc <= cyc + 1;

  // VRAM model: read data appears LAT cycles after the mem_rd cycle, garbage otherwise.
  logic [15:0] mem [0:32767];
  logic [1:0]  rd_v = 2'b00;
  logic [14:0] rd_a0, rd_a1;

  always @(posedge clk_bus) begin
    if (cyc == 0) begin
      mem[15'h4123] <= 16'hA5A5;
      mem[15'h0200] <= 16'hBEEF;
      mem[15'h1111] <= 16'hC0DE;
      mem[15'h2222] <= 16'h2D2D;
      mem[15'h0011] <= 16'h0F11;
      mem[15'h0022] <= 16'h0F22;
      mem[15'h0033] <= 16'h0F33;
      mem[15'h3333] <= 16'h3C3C;
      mem[15'h4777] <= 16'h7E77;
    end
    if (mem_we) begin
      if (mem_be[0]) mem[mem_addr][7:0]  <= mem_din[7:0];
      if (mem_be[1]) mem[mem_addr][15:8] <= mem_din[15:8];
    end
    rd_v  <= {rd_v[0], mem_rd};
    rd_a0 <= mem_addr;
    rd_a1 <= rd_a0;
  end

  assign mem_dout = rd_v[1] ? mem[rd_a1] : 16'hDEAD;

  // Event log sampled mid-cycle, away from the active edge.
  int          n_rd = 0, n_we = 0, n_both = 0, n_vv = 0, n_ack = 0;
  int          rd_cyc, we_cyc, vv_cyc, ack_cyc;
  logic [14:0] rd_addr, we_addr;
  logic [1:0]  rd_be, we_be;
  logic [15:0] we_din, vv_data;

  always @(negedge clk_bus) begin
    if (mem_rd) begin
      n_rd++; rd_cyc = cyc; rd_addr = mem_addr; rd_be = mem_be;
    end
    if (mem_we) begin
      n_we++; we_cyc = cyc; we_addr = mem_addr; we_din = mem_din; we_be = mem_be;
    end
    if (mem_rd && mem_we) n_both++;
    if (vid_valid) begin
      n_vv++; vv_cyc = cyc; vv_data = vid_data;
    end
    if (cpu_ack) begin
      n_ack++; ack_cyc = cyc;
    end
  end

  int n_vec = 0, n_err = 0;
  int t, s, rd0, we0, vv0, ack0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    rd0 = n_rd; we0 = n_we; vv0 = n_vv; ack0 = n_ack;
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_strobes"}, {27'd0, vid_valid, vid_overrun, cpu_ack, mem_we, mem_rd}, 32'd0);
    check({tag, "_vid_data"}, 32'(vid_data), 32'd0);
    check({tag, "_cpu_dout"}, 32'(cpu_dout), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_din"},  32'(mem_din),  32'd0);
    check({tag, "_mem_be"},   32'(mem_be),   32'd3);
  endtask

  initial begin
    reset = 1'b1; vid_req = 1'b0; vid_addr = '0; vid_bank = 1'b0;
    cpu_stb = 1'b0; cpu_we = 1'b0; cpu_wtbt = 2'b00; cpu_addr = '0; cpu_din = '0;
    run(3);
    @(negedge clk_bus);
    check_rst("reset");
    reset = 1'b0;
    run(2);

    // Single video fetch: bank 1, address 0x0123.
    snap();
    vid_bank = 1'b1; vid_addr = 14'h0123; vid_req = 1'b1; t = cyc + 1;
    tick();
    vid_req = 1'b0;
    run(6);
    check("vid_rd_addr", 32'(rd_addr), 32'h4123);
    check("vid_rd_cyc", rd_cyc, t);
    check("vid_latency", vv_cyc - t, LAT + 1);
    check("vid_data", 32'(vv_data), 32'hA5A5);
    check("vid_count", n_vv - vv0, 1);
    check("vid_rd_be", 32'(rd_be), 32'd3);

    // Video and CPU read in the same IDLE cycle: video wins.
    snap();
    vid_bank = 1'b0; vid_addr = 14'h0200; vid_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 15'h1111; cpu_stb = 1'b1; t = cyc + 1;
    tick();
    vid_req = 1'b0;
    run(10);
    cpu_stb = 1'b0;
    tick();
    check("both_vid_data", 32'(vv_data), 32'hBEEF);
    check("both_vid_cyc", vv_cyc, t + 3);
    check("both_cpu_rd_cyc", rd_cyc, vv_cyc + 1);
    check("both_cpu_rd_addr", 32'(rd_addr), 32'h1111);
    check("both_ack_cyc", ack_cyc, rd_cyc + LAT + 1);
    check("both_cpu_dout", 32'(cpu_dout), 32'hC0DE);
    check("both_rd_count", n_rd - rd0, 2);
    check("both_ack_count", n_ack - ack0, 1);

    // Full-word write, then high-byte-only write.
    for (int i = 0; i < 2; i++) begin
      snap();
      cpu_we = 1'b1; cpu_wtbt = (i == 0) ? 2'b00 : 2'b10;
      cpu_din = 16'h1234; cpu_addr = 15'h0040; cpu_stb = 1'b1; s = cyc;
      run(4);
      cpu_stb = 1'b0;
      tick();
      check($sformatf("wr%0d_be", i), 32'(we_be), (i == 0) ? 32'd3 : 32'd2);
      check($sformatf("wr%0d_we_count", i), n_we - we0, 1);
      check($sformatf("wr%0d_addr", i), 32'(we_addr), 32'h0040);
      check($sformatf("wr%0d_din", i), 32'(we_din), 32'h1234);
      check($sformatf("wr%0d_we_cyc", i), we_cyc, s + 1);
      check($sformatf("wr%0d_ack_cyc", i), ack_cyc, s + 2);
      check($sformatf("wr%0d_rd_count", i), n_rd - rd0, 0);
    end
    check("wr_dout_held", 32'(cpu_dout), 32'hC0DE);

    // Three video requests during a CPU read whose strobe drops early.
    snap();
    cpu_we = 1'b0; cpu_wtbt = 2'b00; cpu_addr = 15'h2222; cpu_stb = 1'b1;
    tick();
    vid_bank = 1'b0; vid_req = 1'b1; vid_addr = 14'h0011;
    tick();
    vid_addr = 14'h0022;
    tick();
    vid_addr = 14'h0033;
    tick();
    vid_req = 1'b0; cpu_stb = 1'b0;
    run(10);
    check("ovr_ack_count", n_ack - ack0, 1);
    check("ovr_cpu_dout", 32'(cpu_dout), 32'h2D2D);
    check("ovr_vv_count", n_vv - vv0, 1);
    check("ovr_vid_data", 32'(vv_data), 32'h0F11);
    check("ovr_rd_count", n_rd - rd0, 2);
    check("ovr_flag", 32'(vid_overrun), 32'd1);
    run(5);
    check("ovr_sticky", 32'(vid_overrun), 32'd1);

    // Strobe held for many cycles past cpu_ack: one access only.
    snap();
    cpu_we = 1'b1; cpu_din = 16'h5555; cpu_addr = 15'h0050; cpu_stb = 1'b1;
    run(14);
    check("hold_we_count", n_we - we0, 1);
    check("hold_rd_count", n_rd - rd0, 0);
    check("hold_ack_count", n_ack - ack0, 1);
    cpu_stb = 1'b0;
    tick();
    snap();
    cpu_we = 1'b0; cpu_stb = 1'b1;
    run(6);
    cpu_stb = 1'b0;
    check("rearm_rd_count", n_rd - rd0, 1);
    check("rearm_cpu_dout", 32'(cpu_dout), 32'h5555);
    check("rearm_ack_count", n_ack - ack0, 1);
    tick();

    // Reset one cycle after a CPU read's mem_rd abandons the access.
    snap();
    cpu_we = 1'b0; cpu_addr = 15'h3333; cpu_stb = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk_bus);
    check_rst("midrst");
    reset = 1'b0;
    run(8);
    check("midrst_ack_count", n_ack - ack0, 0);
    check("midrst_rd_count", n_rd - rd0, 1);
    check("midrst_vv_count", n_vv - vv0, 0);
    cpu_stb = 1'b0;
    tick();
    snap();
    vid_bank = 1'b1; vid_addr = 14'h0777; vid_req = 1'b1; t = cyc + 1;
    tick();
    vid_req = 1'b0;
    run(6);
    check("post_rst_vid_data", 32'(vv_data), 32'h7E77);
    check("post_rst_vid_cyc", vv_cyc, t + LAT + 1);
    check("post_rst_vv_count", n_vv - vv0, 1);
    check("rd_we_exclusive", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 2, meaning the VRAM read latency in clk_bus cycles from a mem_rd pulse to valid mem_dout (legal range 1..7).
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk_bus  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- vid_req  in  1  one-cycle pulse, video word fetch request.
- vid_addr  in  14  video word address {bank-relative row, column}, sampled with vid_req.
- vid_bank  in  1  screen bank, sampled with vid_req.
- vid_data  out  16  fetched video word.
- vid_valid  out  1  one-cycle pulse, vid_data valid.
- vid_overrun  out  1  sticky flag, a video request was lost.
- cpu_stb  in  1  CPU access strobe, level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read, sampled at acceptance.
- cpu_wtbt  in  2  byte enables {hi, lo}; 2'b00 on write means a full word.
- cpu_addr  in  15  CPU word address {bank, word}.
- cpu_din  in  16  CPU write data.
- cpu_dout  out  16  CPU read data.
- cpu_ack  out  1  one-cycle pulse, access complete.
- mem_addr  out  15  VRAM word address.
- mem_din  out  16  VRAM write data.
- mem_be  out  2  VRAM byte enables.
- mem_we  out  1  one-cycle write strobe.
- mem_rd  out  1  one-cycle read strobe.
- mem_dout  in  16  VRAM read data, valid MEM_LAT cycles after mem_rd.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, VID, CPU_RD, CPU_WR and DONE.
REQ-004 In IDLE, a video request (vid_req or latched pending) SHALL go to VID; otherwise an armed cpu_stb SHALL go to CPU_WR if cpu_we = 1, else CPU_RD; otherwise IDLE SHALL remain.
REQ-005 When video and CPU requests are both present in IDLE, video SHALL win and the CPU SHALL wait with cpu_stb held.
REQ-006 On entry to VID, mem_rd SHALL pulse for the first cycle with mem_addr = {vid_bank, vid_addr} as latched at request time.
REQ-007 A latency counter SHALL capture mem_dout MEM_LAT cycles after mem_rd into vid_data, pulse vid_valid, and return to IDLE in the same cycle.
REQ-008 The time from vid_req sampled in IDLE to vid_valid SHALL be exactly MEM_LAT+1 cycles.
REQ-009 A vid_req arriving while the FSM is not IDLE SHALL be latched, with its address and bank, in a one-entry pending register and served on the next IDLE cycle ahead of the CPU.
REQ-010 A vid_req arriving while the pending entry is full SHALL be dropped, the existing entry kept, and vid_overrun set.
REQ-011 vid_overrun SHALL clear only on reset.
REQ-012 CPU_RD SHALL pulse mem_rd with mem_addr = cpu_addr, capture mem_dout into cpu_dout after MEM_LAT cycles, then enter DONE.
REQ-013 cpu_dout SHALL hold its value until the next CPU read completes.
REQ-014 CPU_WR SHALL pulse mem_we for one cycle with mem_addr = cpu_addr, mem_din = cpu_din, mem_be = (cpu_wtbt == 2'b00) ? 2'b11 : cpu_wtbt, then enter DONE.
REQ-015 DONE SHALL pulse cpu_ack for one cycle, disarm the CPU port and return to IDLE.
REQ-016 The CPU port SHALL re-arm only after cpu_stb has been sampled low, so a strobe held past cpu_ack SHALL NOT start a second access.
REQ-017 mem_rd and mem_we SHALL never be high in the same cycle, and at most one memory strobe SHALL be issued per access.
REQ-018 cpu_stb dropping before cpu_ack SHALL NOT abort an access already accepted.
REQ-019 mem_be SHALL be 2'b11 during reads.

Reset
REQ-020 When reset is high, the FSM SHALL go to IDLE and the pending entry and latency counter SHALL clear.
REQ-021 When reset is high, the CPU port SHALL be disarmed until cpu_stb is sampled low.
REQ-022 When reset is high, vid_valid, vid_overrun, cpu_ack, mem_we and mem_rd SHALL be 0.
REQ-023 When reset is high, vid_data, cpu_dout, mem_addr and mem_din SHALL be 0, and mem_be SHALL be 2'b11.
REQ-024 Reset asserted mid-access SHALL abandon the access with no cpu_ack or vid_valid afterwards.

Structure
REQ-025 The FSM state enum and the MEM_LAT default SHALL live in shared package vram_pkg.
REQ-026 The one-entry video pending register SHALL be a sub-module named vram_req_latch.
REQ-027 No other sub-modules SHALL be used.

Verification
REQ-028 MEM_LAT = 2, vid_req with vid_bank = 1, vid_addr = 14'h0123, mem_dout = 16'hA5A5 -> mem_rd with mem_addr = 15'h4123; vid_valid with vid_data = 16'hA5A5 three cycles after vid_req.
REQ-029 vid_req and an armed CPU read in the same IDLE cycle -> video served first; the CPU read issues mem_rd on the cycle after vid_valid; cpu_ack follows MEM_LAT+1 cycles after that mem_rd.
REQ-030 CPU write with cpu_wtbt = 2'b00, then 2'b10, cpu_din = 16'h1234, cpu_addr = 15'h0040 -> mem_be = 2'b11 then 2'b10; one mem_we each; cpu_ack two cycles after acceptance.
REQ-031 Three vid_req during one CPU read -> the first is pending and served, the third is dropped, vid_overrun = 1 until reset.
REQ-032 cpu_stb held high for 10 cycles after cpu_ack -> exactly one mem_we or mem_rd; a new access starts only after one low cycle.
REQ-033 reset pulsed one cycle after a CPU read's mem_rd -> no cpu_ack, all outputs at reset values, and the next vid_req is served normally.
